dec_correct_pipe: RTL and testbench

- Two-stage pipelined decoder for the extended-Hamming codewords produced by the encoder; it sits directly downstream of the encoder on the channel side.
- Per codeword it computes the syndrome and overall parity, corrects single errors and flags double errors.
- It extracts right-justified info bits and keeps saturating error-statistics counters.
- Mode selection and codeword layout match the encoder exactly.

---
 rtl/dec_correct_pipe_if.sv | 28 ++
 rtl/dec_correct_pipe.sv | 131 +++++++++++++
 tb/tb_dec_correct_pipe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dec_correct_pipe_if.sv
// Channel-side bus for the extended-Hamming decoder: received codeword in, corrected info and statistics out.
interface dec_correct_pipe_if #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
);
  logic [MAX_CODEWORD_WIDTH-1:0] data_in;
  logic [1:0]                    mod;
  logic                          valid_in;
  logic                          cnt_clr;
  logic [MAX_INFO_WIDTH-1:0]     data_out;
  logic [1:0]                    num_of_errors;
  logic                          valid_out;
  logic [CNT_WIDTH-1:0]          corr_cnt;
  logic [CNT_WIDTH-1:0]          uncorr_cnt;

  // Upstream side: drives codewords and the counter clear.
  modport master (
    output data_in, mod, valid_in, cnt_clr,
    input  data_out, num_of_errors, valid_out, corr_cnt, uncorr_cnt
  );

  // Decoder side.
  modport slave (
    input  data_in, mod, valid_in, cnt_clr,
    output data_out, num_of_errors, valid_out, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/dec_correct_pipe.sv
// Two-stage extended-Hamming decoder for (8,4), (16,11) and (32,26) codes.
// Stage 1 registers the masked codeword with its syndrome and overall parity;
// stage 2 classifies, corrects, extracts info bits and keeps error counters.
// The bit-extraction map assumes the default 32-bit codeword / 26-bit info widths.
module dec_correct_pipe #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
) (
  input logic               clk,
  input logic               rst,
  dec_correct_pipe_if.slave bus
);

  localparam int CW = MAX_CODEWORD_WIDTH;
  localparam int IW = MAX_INFO_WIDTH;

  // Stage-1 combinational signals
  logic [CW-1:0] cw_mask;
  logic [CW-1:0] cw_full;
  logic [CW-1:0] cw_syn;
  logic [4:0]    syn_d;
  logic          par_d;

  // Stage-1 registers
  logic          v1_q;
  logic [CW-1:0] cw_q;
  logic [1:0]    mode_q;
  logic [4:0]    syn_q;
  logic          par_q;

  // Stage-2 combinational signals
  logic [CW-1:0] cw_fix;
  logic [IW-1:0] info_all;
  logic [IW-1:0] info_mask;
  logic [IW-1:0] data_d;
  logic [1:0]    nerr_d;

  // Output and statistics registers
  logic                 vout_q;
  logic [IW-1:0]        data_q;
  logic [1:0]           nerr_q;
  logic [CNT_WIDTH-1:0] corr_q;
  logic [CNT_WIDTH-1:0] uncorr_q;

  // Mask off padding for the selected code length and compute syndrome and overall parity.
  always_comb begin
    case (bus.mod)
      2'b00:   cw_mask = CW'(32'h0000_00FF);
      2'b01:   cw_mask = CW'(32'h0000_FFFF);
      default: cw_mask = CW'(32'hFFFF_FFFF);
    endcase
    cw_full = bus.data_in & cw_mask;
    // The overall parity bit (bit N-1) has no Hamming position, so it is excluded from S.
    cw_syn  = cw_full & (cw_mask >> 1);
    par_d   = ^cw_full;
    syn_d   = 5'd0;
    for (int b = 0; b < CW - 1; b++) begin
      if (cw_syn[b]) syn_d = syn_d ^ 5'(b + 1);
    end
  end

  // Stage 1: capture the word and its checks; only the valid bit is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= bus.valid_in;
      if (bus.valid_in) begin
        cw_q   <= cw_full;
        mode_q <= bus.mod;
        syn_q  <= syn_d;
        par_q  <= par_d;
      end
    end
  end

  // Classify, correct the flagged position and pick the info bits for the carried mode.
  always_comb begin
    cw_fix = cw_q;
    if (par_q && (syn_q != 5'd0)) cw_fix = cw_q ^ (CW'(1) << (syn_q - 5'd1));

    // Info positions are the non-powers-of-two 3,5,6,7,9..15,17..31 for every mode;
    // shorter codes simply use a prefix of that sequence.
    info_all = {cw_fix[30:16], cw_fix[14:8], cw_fix[6:4], cw_fix[2]};

    case (mode_q)
      2'b00:   info_mask = IW'(26'h000_000F);
      2'b01:   info_mask = IW'(26'h000_07FF);
      default: info_mask = IW'(26'h3FF_FFFF);
    endcase
    data_d = info_all & info_mask;

    if (par_q)                nerr_d = 2'd1;
    else if (syn_q != 5'd0)   nerr_d = 2'd2;
    else                      nerr_d = 2'd0;
  end

  // Stage 2: register results; data and error class hold through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vout_q <= 1'b0;
      data_q <= '0;
      nerr_q <= 2'd0;
    end else begin
      vout_q <= v1_q;
      if (v1_q) begin
        data_q <= data_d;
        nerr_q <= nerr_d;
      end
    end
  end

  // Saturating error statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (v1_q) begin
      if ((nerr_d == 2'd1) && (corr_q != '1))   corr_q   <= corr_q + 1'b1;
      if ((nerr_d == 2'd2) && (uncorr_q != '1)) uncorr_q <= uncorr_q + 1'b1;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.num_of_errors = nerr_q;
  assign bus.valid_out     = vout_q;
  assign bus.corr_cnt      = corr_q;
  assign bus.uncorr_cnt    = uncorr_q;

endmodule

// File: tb/tb_dec_correct_pipe.sv
// Directed, table-driven bench for dec_correct_pipe with hand-computed expectations.
module tb_dec_correct_pipe;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] din;
    logic [25:0] exp_data;
    logic [1:0]  exp_nerr;
  } vec_t;

  localparam int NVEC = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_corr;
  int   exp_uncorr;
  vec_t vecs[NVEC];

  dec_correct_pipe_if #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(16)) bus ();

  dec_correct_pipe #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
  endfunction

  task automatic count(input logic [1:0] nerr);
    if (nerr == 2'd1) exp_corr   = sat_inc(exp_corr);
    if (nerr == 2'd2) exp_uncorr = sat_inc(exp_uncorr);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " corr_cnt"},   32'(bus.corr_cnt),   32'(exp_corr));
    chk({tag, " uncorr_cnt"}, 32'(bus.uncorr_cnt), 32'(exp_uncorr));
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] d);
    bus.valid_in = v;
    bus.mod      = m;
    bus.data_in  = d;
  endtask

  // One isolated word: checks latency, decoded result and counters.
  task automatic apply_one(input int idx);
    @(negedge clk);
    drive(1'b1, vecs[idx].mode, vecs[idx].din);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0);
    chk($sformatf("v%0d early valid_out", idx), 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    count(vecs[idx].exp_nerr);
    chk($sformatf("v%0d valid_out", idx), 32'(bus.valid_out), 32'd1);
    chk($sformatf("v%0d data_out", idx), 32'(bus.data_out), 32'(vecs[idx].exp_data));
    chk($sformatf("v%0d num_of_errors", idx), 32'(bus.num_of_errors), 32'(vecs[idx].exp_nerr));
    chk_counters($sformatf("v%0d", idx));
  endtask

  initial begin
    checks = 0; errors = 0; exp_corr = 0; exp_uncorr = 0;

    vecs[0]  = '{2'b00, 32'h0000_0055, 26'h000_000B, 2'd0};
    vecs[1]  = '{2'b00, 32'h0000_0045, 26'h000_000B, 2'd1};
    vecs[2]  = '{2'b00, 32'h0000_00D5, 26'h000_000B, 2'd1};
    vecs[3]  = '{2'b00, 32'h0000_0056, 26'h000_000B, 2'd2};
    vecs[4]  = '{2'b10, 32'h4000_0000, 26'h000_0000, 2'd1};
    vecs[5]  = '{2'b01, 32'hFFFF_0000, 26'h000_0000, 2'd0};
    vecs[6]  = '{2'b00, 32'hFFFF_FF55, 26'h000_000B, 2'd0};
    vecs[7]  = '{2'b01, 32'h0000_8007, 26'h000_0001, 2'd0};
    vecs[8]  = '{2'b01, 32'h0000_8207, 26'h000_0001, 2'd1};
    vecs[9]  = '{2'b01, 32'h0000_8004, 26'h000_0001, 2'd2};
    vecs[10] = '{2'b10, 32'h4000_808B, 26'h200_0000, 2'd0};
    vecs[11] = '{2'b10, 32'h4000_8083, 26'h200_0000, 2'd1};
    vecs[12] = '{2'b11, 32'h4000_808B, 26'h200_0000, 2'd0};
    vecs[13] = '{2'b11, 32'h8000_0000, 26'h000_0000, 2'd1};
    vecs[14] = '{2'b00, 32'h0000_00FF, 26'h000_000F, 2'd0};

    rst = 1'b1;
    bus.cnt_clr = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    chk("reset num_of_errors", 32'(bus.num_of_errors), 32'd0);
    chk_counters("reset");
    rst = 1'b0;

    // Isolated words
    for (int i = 0; i < NVEC; i++) apply_one(i);

    // Outputs hold through bubbles
    @(negedge clk);
    chk("hold valid_out", 32'(bus.valid_out), 32'd0);
    chk("hold data_out", 32'(bus.data_out), 32'(vecs[NVEC-1].exp_data));
    chk("hold num_of_errors", 32'(bus.num_of_errors), 32'(vecs[NVEC-1].exp_nerr));

    // Back-to-back stream with mixed modes
    for (int i = 0; i < NVEC + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        count(vecs[i-2].exp_nerr);
        chk($sformatf("s%0d valid_out", i-2), 32'(bus.valid_out), 32'd1);
        chk($sformatf("s%0d data_out", i-2), 32'(bus.data_out), 32'(vecs[i-2].exp_data));
        chk($sformatf("s%0d num_of_errors", i-2), 32'(bus.num_of_errors), 32'(vecs[i-2].exp_nerr));
      end
      if (i < NVEC) drive(1'b1, vecs[i].mode, vecs[i].din);
      else          drive(1'b0, 2'b00, 32'h0);
    end
    chk_counters("stream");

    // Clear, then count up to 0xFFFE
    @(negedge clk);
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    chk_counters("clear");
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 2'b00, 32'h45);
      @(negedge clk);
    end
    drive(1'b0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    exp_corr = 16'hFFFE;
    chk_counters("preload");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 32'h45);
      @(negedge clk);
    end
    drive(1'b0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    exp_corr = 16'hFFFF;
    chk_counters("saturate");

    // Clear coincident with a valid single-error result
    drive(1'b1, 2'b00, 32'h45);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0);
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    chk("clr-priority valid_out", 32'(bus.valid_out), 32'd1);
    chk("clr-priority num_of_errors", 32'(bus.num_of_errors), 32'd1);
    chk_counters("clr-priority");

    // Make counters and outputs nonzero before the reset test
    apply_one(3);
    apply_one(1);

    // Reset with two words in flight, then a word right after deassert
    @(negedge clk);
    drive(1'b1, vecs[2].mode, vecs[2].din);
    @(negedge clk);
    drive(1'b1, vecs[3].mode, vecs[3].din);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, vecs[10].mode, vecs[10].din);
    exp_corr = 0; exp_uncorr = 0;
    chk("rst valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst data_out", 32'(bus.data_out), 32'd0);
    chk("rst num_of_errors", 32'(bus.num_of_errors), 32'd0);
    chk_counters("rst");
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0);
    chk("post-rst discard valid_out", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    chk("post-rst valid_out", 32'(bus.valid_out), 32'd1);
    chk("post-rst data_out", 32'(bus.data_out), 32'(vecs[10].exp_data));
    chk("post-rst num_of_errors", 32'(bus.num_of_errors), 32'(vecs[10].exp_nerr));
    chk_counters("post-rst");
    @(negedge clk);
    chk("post-rst bubble valid_out", 32'(bus.valid_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
